// File: rtl/spi_reg_target.sv
// SPI target with an on-chip register file: pins are sampled in the clk domain, a command
// byte selects read/write and start address, then an unbounded burst of data words follows.
module spi_reg_target #(
   parameter int  NUM_REGS = 8,
   parameter int  DATA_W   = 8,
   parameter int  AUTO_INC = 1,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs_n,
   input  logic                       sck,
   input  logic                       mosi,
   input  logic [1:0]                 mode,
   output logic                       miso,
   output logic                       miso_oe,
   input  logic                       loc_we,
   input  logic [AW-1:0]              loc_addr,
   input  logic [DATA_W-1:0]          loc_data,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic                       wr_strobe,
   output logic [AW-1:0]              wr_addr,
   output logic                       busy,
   output logic                       frame_err
);

   localparam int CW = $clog2(DATA_W) + 1;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_CMD     = 2'b01;
   localparam logic [1:0] ST_DATA    = 2'b10;
   localparam logic [1:0] ST_WAIT_HI = 2'b11;

   logic [2:0]        cs_sync_q, sck_sync_q;
   logic [1:0]        mosi_sync_q;
   logic [1:0]        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [CW-1:0]     bitcnt_q, bitcnt_d, last_bit;
   logic              rw_q, rw_d;
   logic [AW-1:0]     addr_q, addr_d, cmd_addr, next_addr;
   logic [DATA_W-1:0] rx_q, rx_d, rx_word;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              miso_q, miso_d;
   logic              busy_q, busy_d;
   logic              frame_err_q, frame_err_d;
   logic              wr_pend_q, wr_pend_d;
   logic [AW-1:0]     wr_pend_addr_q, wr_pend_addr_d;
   logic [DATA_W-1:0] wr_pend_data_q, wr_pend_data_d;
   logic              wr_strobe_q;
   logic [AW-1:0]     wr_addr_q;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              cs_s, cs_fall, cs_rise, sck_rise, sck_fall;
   logic              lead_edge, trail_edge, sample_edge, shift_edge;

   // Pin synchronisers; deliberately left out of reset so a mid-frame reset still sees cs_n.
   always_ff @(posedge clk) begin
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      sck_sync_q  <= {sck_sync_q[1:0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
   end

   assign cs_s        = cs_sync_q[1];
   assign cs_fall     = cs_sync_q[2] & ~cs_sync_q[1];
   assign cs_rise     = ~cs_sync_q[2] & cs_sync_q[1];
   assign sck_rise    = ~sck_sync_q[2] & sck_sync_q[1];
   assign sck_fall    = sck_sync_q[2] & ~sck_sync_q[1];
   assign lead_edge   = mode_q[1] ? sck_fall : sck_rise;
   assign trail_edge  = mode_q[1] ? sck_rise : sck_fall;
   assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
   assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

   assign rx_word   = {rx_q[DATA_W-2:0], mosi_sync_q[1]};
   assign cmd_addr  = rx_word[AW-1:0];
   assign next_addr = (AUTO_INC != 0) ? addr_q + AW'(1) : addr_q;
   assign last_bit  = (state_q == ST_CMD) ? CW'(7) : CW'(DATA_W - 1);
   assign busy_d    = (state_d == ST_CMD) || (state_d == ST_DATA);

   // Frame decoder: command byte, then data words until cs_n rises.
   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      bitcnt_d       = bitcnt_q;
      rw_d           = rw_q;
      addr_d         = addr_q;
      rx_d           = rx_q;
      tx_d           = tx_q;
      miso_d         = miso_q;
      frame_err_d    = frame_err_q;
      wr_pend_d      = 1'b0;
      wr_pend_addr_d = wr_pend_addr_q;
      wr_pend_data_d = wr_pend_data_q;
      case (state_q)
         ST_WAIT_HI: begin
            if (cs_s) state_d = ST_IDLE;
            else      state_d = ST_WAIT_HI;
         end
         ST_IDLE: begin
            if (cs_fall) begin
               state_d     = ST_CMD;
               mode_d      = mode;
               frame_err_d = 1'b0;
               bitcnt_d    = '0;
               tx_d        = '0;
               miso_d      = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD, ST_DATA: begin
            if (cs_rise) begin
               state_d  = ST_IDLE;
               miso_d   = 1'b0;
               bitcnt_d = '0;
               if (bitcnt_q != '0) frame_err_d = 1'b1;
               else                frame_err_d = frame_err_q;
            end else if (sample_edge) begin
               rx_d = rx_word;
               if (bitcnt_q != last_bit) begin
                  bitcnt_d = bitcnt_q + CW'(1);
               end else if (state_q == ST_CMD) begin
                  bitcnt_d = '0;
                  state_d  = ST_DATA;
                  addr_d   = cmd_addr;
                  rw_d     = rx_word[7];
                  if (rx_word[7]) tx_d = regs_q[cmd_addr];
                  else            tx_d = '0;
               end else begin
                  bitcnt_d = '0;
                  addr_d   = next_addr;
                  if (rw_q) begin
                     tx_d = regs_q[next_addr];
                  end else begin
                     wr_pend_d      = 1'b1;
                     wr_pend_addr_d = addr_q;
                     wr_pend_data_d = rx_word;
                  end
               end
            end else if (shift_edge) begin
               miso_d = tx_q[DATA_W-1];
               tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_WAIT_HI;
      endcase
   end

   // Decoder state; reset parks in WAIT_HI so a frame already in progress is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_WAIT_HI;
         mode_q         <= 2'b00;
         bitcnt_q       <= '0;
         rw_q           <= 1'b0;
         addr_q         <= '0;
         rx_q           <= '0;
         tx_q           <= '0;
         miso_q         <= 1'b0;
         busy_q         <= 1'b0;
         frame_err_q    <= 1'b0;
         wr_pend_q      <= 1'b0;
         wr_pend_addr_q <= '0;
         wr_pend_data_q <= '0;
      end else begin
         state_q        <= state_d;
         mode_q         <= mode_d;
         bitcnt_q       <= bitcnt_d;
         rw_q           <= rw_d;
         addr_q         <= addr_d;
         rx_q           <= rx_d;
         tx_q           <= tx_d;
         miso_q         <= miso_d;
         busy_q         <= busy_d;
         frame_err_q    <= frame_err_d;
         wr_pend_q      <= wr_pend_d;
         wr_pend_addr_q <= wr_pend_addr_d;
         wr_pend_data_q <= wr_pend_data_d;
      end
   end

   // Register file: the SPI write commits one cycle after its last sample and wins collisions.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         if (loc_we && !(wr_pend_q && (loc_addr == wr_pend_addr_q))) regs_q[loc_addr] <= loc_data;
         if (wr_pend_q) begin
            regs_q[wr_pend_addr_q] <= wr_pend_data_q;
            wr_addr_q              <= wr_pend_addr_q;
         end
         wr_strobe_q <= wr_pend_q;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign miso      = miso_q;
   assign miso_oe   = busy_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: acts as SPI controller with 5-cycle sck half periods.
module tb_spi_reg_target;

   localparam int H = 5;

   logic        clk = 1'b0;
   logic        rst, cs_n, sck, mosi, loc_we;
   logic [1:0]  mode, cur_mode;
   logic [2:0]  loc_addr;
   logic [7:0]  loc_data;
   logic        miso, miso_oe, wr_strobe, busy, frame_err;
   logic [63:0] regs_flat;
   logic [2:0]  wr_addr;
   logic        miso2, miso_oe2, wr_strobe2, busy2, frame_err2;
   logic [63:0] regs_flat2;
   logic [2:0]  wr_addr2;
   logic [31:0] rxv;
   logic [2:0]  strobe_log[$];
   int          n_vec = 0;
   int          n_err = 0;

   spi_reg_target #(.NUM_REGS(8), .DATA_W(8), .AUTO_INC(1)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi), .mode(mode),
      .miso(miso), .miso_oe(miso_oe), .loc_we(loc_we), .loc_addr(loc_addr),
      .loc_data(loc_data), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .busy(busy), .frame_err(frame_err));

   spi_reg_target #(.NUM_REGS(8), .DATA_W(8), .AUTO_INC(0)) dut2 (
      .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi), .mode(mode),
      .miso(miso2), .miso_oe(miso_oe2), .loc_we(loc_we), .loc_addr(loc_addr),
      .loc_data(loc_data), .regs_flat(regs_flat2), .wr_strobe(wr_strobe2),
      .wr_addr(wr_addr2), .busy(busy2), .frame_err(frame_err2));

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_strobe === 1'b1) strobe_log.push_back(wr_addr);

   function automatic logic [7:0] rg(input logic [63:0] flat, input int i);
      return flat[i*8 +: 8];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_begin(input logic [1:0] m, input bit chk);
      mode = m; cur_mode = m; sck = m[1];
      tick(H);
      cs_n = 1'b0;
      if (chk) begin
         tick(2);
         n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_rise_early: got %b want 0", busy); end
         tick(1);
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_rise: got %b want 1", busy); end
         n_vec++; if (miso_oe !== 1'b1) begin n_err++; $display("FAIL miso_oe_rise: got %b want 1", miso_oe); end
         tick(H - 3);
      end else begin
         tick(H);
      end
   endtask

   task automatic frame_end(input bit chk, input logic exp_err);
      tick(H);
      cs_n = 1'b1;
      if (chk) begin
         tick(2);
         n_vec++; if (busy !== 1'b1 || frame_err !== 1'b0) begin n_err++; $display("FAIL end_early: busy %b err %b want 1 0", busy, frame_err); end
         tick(1);
         n_vec++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin n_err++; $display("FAIL busy_fall: busy %b oe %b want 0 0", busy, miso_oe); end
         n_vec++; if (frame_err !== exp_err) begin n_err++; $display("FAIL frame_err_end: got %b want %b", frame_err, exp_err); end
         tick(H - 3);
      end else begin
         tick(H);
      end
   endtask

   task automatic spi_word(input int nbits, input logic [31:0] val, input bit chk_wr,
                           input bit loc_en, input logic [2:0] la, input logic [7:0] ld,
                           output logic [31:0] rx);
      rx = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         if (cur_mode[0] == 1'b0) begin
            mosi = val[i];
            tick(H);
            sck = ~cur_mode[1];
         end else begin
            sck  = ~cur_mode[1];
            mosi = val[i];
            tick(H);
            sck = cur_mode[1];
         end
         rx = {rx[30:0], miso};
         if (i == 0 && (chk_wr || loc_en)) begin
            tick(3);
            if (chk_wr) begin
               n_vec++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL strobe_early: got %b want 0", wr_strobe); end
            end
            if (loc_en) begin loc_we = 1'b1; loc_addr = la; loc_data = ld; end
            tick(1);
            loc_we = 1'b0;
            if (chk_wr) begin
               n_vec++; if (wr_strobe !== 1'b1) begin n_err++; $display("FAIL strobe_pulse: got %b want 1", wr_strobe); end
            end
            tick(H - 4);
         end else begin
            tick(H);
         end
         if (cur_mode[0] == 1'b0) sck = cur_mode[1];
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; mode = 2'b00; cur_mode = 2'b00;
      loc_we = 1'b0; loc_addr = 3'd0; loc_data = 8'h00;
      tick(6);
      n_vec++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin n_err++; $display("FAIL rst_miso: miso %b oe %b want 0 0", miso, miso_oe); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
      n_vec++; if (wr_strobe !== 1'b0 || wr_addr !== 3'd0) begin n_err++; $display("FAIL rst_wr: strobe %b addr %0d want 0 0", wr_strobe, wr_addr); end
      n_vec++; if (regs_flat !== 64'h0) begin n_err++; $display("FAIL rst_regs: got %h want 0", regs_flat); end
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_write_mode0;
      strobe_log.delete();
      frame_begin(2'b00, 1'b1);
      spi_word(8, 32'h02, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'hA5, 1'b1, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'h3C, 1'b1, 1'b0, 3'd0, 8'h00, rxv);
      frame_end(1'b1, 1'b0);
      n_vec++; if (rg(regs_flat, 2) !== 8'hA5) begin n_err++; $display("FAIL wr_reg2: got %h want a5", rg(regs_flat, 2)); end
      n_vec++; if (rg(regs_flat, 3) !== 8'h3C) begin n_err++; $display("FAIL wr_reg3: got %h want 3c", rg(regs_flat, 3)); end
      n_vec++; if (strobe_log.size() != 2) begin n_err++; $display("FAIL wr_strobe_count: got %0d want 2", strobe_log.size()); end
      else if (strobe_log[0] !== 3'd2 || strobe_log[1] !== 3'd3) begin n_err++; $display("FAIL wr_addr_seq: got %0d %0d want 2 3", strobe_log[0], strobe_log[1]); end
      n_vec++; if (rg(regs_flat2, 2) !== 8'h3C) begin n_err++; $display("FAIL noinc_reg2: got %h want 3c", rg(regs_flat2, 2)); end
   endtask

   task automatic test_read_mode3;
      strobe_log.delete();
      frame_begin(2'b11, 1'b0);
      spi_word(8, 32'h82, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      n_vec++; if (rxv[7:0] !== 8'h00) begin n_err++; $display("FAIL rd_cmd_miso: got %h want 00", rxv[7:0]); end
      spi_word(8, 32'h00, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      n_vec++; if (rxv[7:0] !== 8'hA5) begin n_err++; $display("FAIL rd_word0: got %h want a5", rxv[7:0]); end
      spi_word(8, 32'hFF, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      n_vec++; if (rxv[7:0] !== 8'h3C) begin n_err++; $display("FAIL rd_word1: got %h want 3c", rxv[7:0]); end
      spi_word(8, 32'h00, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      n_vec++; if (rxv[7:0] !== 8'h00) begin n_err++; $display("FAIL rd_word2: got %h want 00", rxv[7:0]); end
      frame_end(1'b1, 1'b0);
      n_vec++; if (strobe_log.size() != 0) begin n_err++; $display("FAIL rd_no_strobe: got %0d want 0", strobe_log.size()); end
   endtask

   task automatic test_wrap;
      frame_begin(2'b00, 1'b0);
      spi_word(8, 32'h07, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'h11, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'h22, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      frame_end(1'b0, 1'b0);
      n_vec++; if (rg(regs_flat, 7) !== 8'h11 || rg(regs_flat, 0) !== 8'h22) begin n_err++; $display("FAIL wrap_regs: r7 %h r0 %h want 11 22", rg(regs_flat, 7), rg(regs_flat, 0)); end
      n_vec++; if (wr_addr !== 3'd0) begin n_err++; $display("FAIL wrap_wr_addr: got %0d want 0", wr_addr); end
      n_vec++; if (rg(regs_flat2, 7) !== 8'h22 || rg(regs_flat2, 0) !== 8'h00) begin n_err++; $display("FAIL noinc_regs: r7 %h r0 %h want 22 00", rg(regs_flat2, 7), rg(regs_flat2, 0)); end
   endtask

   task automatic test_abort;
      strobe_log.delete();
      frame_begin(2'b00, 1'b0);
      spi_word(8, 32'h01, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(5, 32'h1B, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      frame_end(1'b1, 1'b1);
      n_vec++; if (rg(regs_flat, 1) !== 8'h00) begin n_err++; $display("FAIL abort_reg1: got %h want 00", rg(regs_flat, 1)); end
      n_vec++; if (strobe_log.size() != 0) begin n_err++; $display("FAIL abort_strobe: got %0d want 0", strobe_log.size()); end
      tick(H);
      cs_n = 1'b0;
      tick(2);
      n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL abort_sticky: got %b want 1", frame_err); end
      tick(1);
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL abort_clear: got %b want 0", frame_err); end
      tick(H - 3);
      frame_end(1'b1, 1'b0);
   endtask

   task automatic test_collision;
      strobe_log.delete();
      frame_begin(2'b00, 1'b0);
      spi_word(8, 32'h04, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'h55, 1'b1, 1'b1, 3'd4, 8'hFF, rxv);
      frame_end(1'b0, 1'b0);
      n_vec++; if (rg(regs_flat, 4) !== 8'h55) begin n_err++; $display("FAIL coll_same: got %h want 55", rg(regs_flat, 4)); end
      frame_begin(2'b00, 1'b0);
      spi_word(8, 32'h04, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'h66, 1'b1, 1'b1, 3'd5, 8'h77, rxv);
      frame_end(1'b0, 1'b0);
      n_vec++; if (rg(regs_flat, 4) !== 8'h66 || rg(regs_flat, 5) !== 8'h77) begin n_err++; $display("FAIL coll_diff: r4 %h r5 %h want 66 77", rg(regs_flat, 4), rg(regs_flat, 5)); end
      n_vec++; if (strobe_log.size() != 2) begin n_err++; $display("FAIL coll_strobes: got %0d want 2", strobe_log.size()); end
   endtask

   task automatic test_local;
      loc_we = 1'b1; loc_addr = 3'd6; loc_data = 8'h9A;
      tick(1);
      loc_we = 1'b0;
      n_vec++; if (rg(regs_flat, 6) !== 8'h9A) begin n_err++; $display("FAIL loc_write: got %h want 9a", rg(regs_flat, 6)); end
      frame_begin(2'b00, 1'b0);
      spi_word(8, 32'h86, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      loc_we = 1'b1; loc_addr = 3'd6; loc_data = 8'h13;
      tick(1);
      loc_we = 1'b0;
      spi_word(8, 32'h00, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      n_vec++; if (rxv[7:0] !== 8'h9A) begin n_err++; $display("FAIL loc_tx_kept: got %h want 9a", rxv[7:0]); end
      spi_word(8, 32'h00, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      n_vec++; if (rxv[7:0] !== 8'h11) begin n_err++; $display("FAIL loc_rd_next: got %h want 11", rxv[7:0]); end
      frame_end(1'b0, 1'b0);
      n_vec++; if (rg(regs_flat, 6) !== 8'h13) begin n_err++; $display("FAIL loc_reg6: got %h want 13", rg(regs_flat, 6)); end
   endtask

   task automatic test_reset_midframe;
      frame_begin(2'b00, 1'b0);
      spi_word(8, 32'h03, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(3, 32'h5, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      rst = 1'b1;
      spi_word(8, 32'hFF, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      rst = 1'b0;
      strobe_log.delete();
      spi_word(8, 32'h03, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'hEE, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      tick(H);
      n_vec++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin n_err++; $display("FAIL mrst_outs: busy %b oe %b miso %b want 0 0 0", busy, miso_oe, miso); end
      n_vec++; if (regs_flat !== 64'h0) begin n_err++; $display("FAIL mrst_regs: got %h want 0", regs_flat); end
      n_vec++; if (strobe_log.size() != 0 || wr_addr !== 3'd0) begin n_err++; $display("FAIL mrst_writes: strobes %0d addr %0d want 0 0", strobe_log.size(), wr_addr); end
      cs_n = 1'b1;
      tick(4);
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mrst_frame_err: got %b want 0", frame_err); end
      tick(H);
      frame_begin(2'b00, 1'b1);
      spi_word(8, 32'h03, 1'b0, 1'b0, 3'd0, 8'h00, rxv);
      spi_word(8, 32'h5A, 1'b1, 1'b0, 3'd0, 8'h00, rxv);
      frame_end(1'b1, 1'b0);
      n_vec++; if (rg(regs_flat, 3) !== 8'h5A) begin n_err++; $display("FAIL mrst_next_frame: got %h want 5a", rg(regs_flat, 3)); end
      n_vec++; if (strobe_log.size() != 1 || wr_addr !== 3'd3) begin n_err++; $display("FAIL mrst_next_strobe: strobes %0d addr %0d want 1 3", strobe_log.size(), wr_addr); end
   endtask

   initial begin
      test_reset();
      test_write_mode0();
      test_read_mode3();
      test_wrap();
      test_abort();
      test_collision();
      test_local();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_reg_target.md
# spi_reg_target

Parametrised SPI target with an on-chip register file, the next generation of the SPI test interface on `uio_in` (cs/mosi/sck). Samples the external SPI pins in the `clk` domain, supports all four SPI modes, and decodes a command byte followed by a burst of data words with auto-increment. Registers are written over SPI, read back on MISO, and can also be updated by local fabric logic. Sits between the pad-level `uio` signals and the design core.

## Interface
Parameters:
- `NUM_REGS`, 8, register count; power of two, 2..128
- `DATA_W`, 8, data word width in bits; 8..32
- `AUTO_INC`, 1, 1 = address increments after each data word, 0 = fixed address for whole burst

Ports (`AW = log2(NUM_REGS)`):
- `clk` in 1 system clock
- `rst` in 1 reset, synchronous, active-high
- `cs_n` in 1 SPI chip select, active low, asynchronous to `clk`
- `sck` in 1 SPI clock, asynchronous
- `mosi` in 1 SPI data in, asynchronous
- `mode` in 2 {CPOL, CPHA}; latched on each synchronised `cs_n` fall
- `miso` out 1 SPI data out
- `miso_oe` out 1 1 while frame active (drives `uio_oe` bit)
- `loc_we` in 1 local write enable
- `loc_addr` in AW local write address
- `loc_data` in DATA_W local write data
- `regs_flat` out NUM_REGS*DATA_W all registers; reg i at bits [i*DATA_W +: DATA_W]
- `wr_strobe` out 1 one-cycle pulse on each SPI register write
- `wr_addr` out AW address of last SPI write
- `busy` out 1 frame active
- `frame_err` out 1 sticky: frame ended mid-word

## Operation
- Inputs pass 2-flop synchronisers, then a third flop for edge detect. Leading edge = first transition away from CPOL; sample edge = leading if CPHA=0 else trailing; shift edge = the other.
- FSM: IDLE, CMD, DATA, WAIT_HI.
- IDLE: on `cs_n` fall latch `mode`, clear `frame_err`, bit counter = 0, tx shifter = 0 -> CMD.
- CMD: shift 8 bits MSB first. Byte: bit7 = 1 read / 0 write, bits[6:0] = address; only low AW bits used. On 8th sample: addr latched; if read, tx shifter loaded with regs[addr] -> DATA. MISO = 0 throughout CMD.
- DATA: DATA_W bits per word, MSB first on both MOSI and MISO.
  - Write: on last sample, regs[addr] <= word, `wr_strobe`=1 one cycle, `wr_addr`=addr.
  - Read: MOSI ignored; at word end tx shifter reloaded with regs[next addr].
  - After each word, addr = addr+1 mod NUM_REGS if AUTO_INC, else unchanged. Bursts are unbounded.
- `cs_n` rise in any state -> IDLE. If bit counter ≠ 0 in CMD or DATA, the partial word is discarded and `frame_err` is set.
- Local port: `loc_we` writes regs[loc_addr] <= loc_data. If an SPI write hits the same address in the same cycle, SPI wins and the local write is dropped. A local write never alters a word already loaded into the tx shifter.
- Reset: every register = 0, FSM -> WAIT_HI, synchronisers are not cleared. WAIT_HI ignores all SPI activity until synchronised `cs_n` = 1, then -> IDLE. This holds when reset lands mid-frame with `cs_n` still low.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `busy`=0, `frame_err`=0, `wr_strobe`=0, `wr_addr`=0, `regs_flat`=0.
- Pin to internal edge: 3 `clk` cycles. `sck` high and low phases must each be ≥ 4 `clk` cycles; `cs_n` setup and hold to the first and last `sck` edge ≥ 4 cycles.
- `miso` updates 3 cycles after each shift edge. For CPHA=0 the first data MSB appears after the trailing edge of command bit 8.
- `wr_strobe` and `regs_flat` update 1 cycle after the internal sample of the last data bit (4 cycles after the pin edge).
- `busy` and `miso_oe` rise 3 cycles after the `cs_n` fall and fall 3 cycles after the `cs_n` rise.
- `frame_err` is set 3 cycles after the `cs_n` rise.
- Local writes are visible on `regs_flat` the cycle after `loc_we`.

## Test plan
- Mode 0, NUM_REGS=8: write cmd 0x02, data 0xA5, 0x3C -> regs[2]=0xA5, regs[3]=0x3C; two `wr_strobe` pulses with `wr_addr` 2 then 3.
- Mode 3: read cmd 0x82 after the previous writes -> MISO returns 0xA5, 0x3C, then regs[4]=0x00; `miso`=0 during the command byte.
- Wrap: write cmd 0x07, data 0x11, 0x22 -> regs[7]=0x11, regs[0]=0x22. With AUTO_INC=0, both words land in regs[7] and regs[7]=0x22.
- Abort: write cmd 0x01 then 5 data bits, `cs_n` rise -> regs[1] unchanged, `frame_err`=1; it clears on the next `cs_n` fall.
- Collision: SPI write of 0x55 to reg 4 with `loc_we` to reg 4 (0xFF) in the same cycle -> regs[4]=0x55. A local write to reg 5 in the same cycle takes effect.
- Reset mid-frame with `cs_n` held low and `sck` toggling -> all outputs 0 and no writes occur until `cs_n` rises; the next frame operates normally.
